// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared RV32I opcode constants and instruction field helpers for the hazard controller.
package hazard_stall_ctrl_pkg;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcAr     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    function automatic logic [6:0] inst_op(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [4:0] inst_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] inst_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] inst_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

endpackage

// File: rtl/hazard_rs_decode.sv
// Combinational D-stage source-register decode: which of rs1/rs2 the instruction really reads.
module hazard_rs_decode
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output logic        use_rs1,
    output logic        use_rs2,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    logic [6:0] op;

    assign op  = inst_op(inst);
    assign rs1 = inst_rs1(inst);
    assign rs2 = inst_rs2(inst);

    // A bubble (all zeros) reads nothing; U-type and JAL carry immediate bits in the rs fields.
    assign use_rs1 = !((inst == 32'd0) || (op == OpcLui) || (op == OpcAuipc) || (op == OpcJal));
    assign use_rs2 = (op == OpcBranch) || (op == OpcStore) || (op == OpcAr);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and data-memory wait holds.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_D,
    input  logic [31:0]      inst_E,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             D_stall,
    output logic             E_stop,
    output logic             E_hold,
    output logic             M_stall,
    output logic             jump_reset,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {StRun, StFlush, StWait} state_e;

    localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES);
    localparam bit         HasFlush  = (FLUSH_CYCLES != 0);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;

    logic       use_rs1, use_rs2;
    logic [4:0] rs1, rs2, rd_e;
    logic       load_use;
    logic       hold, lu_stall, accept;
    logic       unused_inst_e;

    hazard_rs_decode u_rs_decode (
        .inst    (inst_D),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .rs1     (rs1),
        .rs2     (rs2)
    );

    assign rd_e          = inst_rd(inst_E);
    assign unused_inst_e = ^inst_E[31:12];
    assign load_use      = (inst_op(inst_E) == OpcLoad) && (rd_e != 5'd0) &&
                           ((use_rs1 && (rs1 == rd_e)) || (use_rs2 && (rs2 == rd_e)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            StRun: begin
                if (mem_busy) begin
                    state_d = StWait;
                    pend_d  = branch_taken;
                end else if (branch_taken && HasFlush) begin
                    state_d = StFlush;
                    cnt_d   = FlushInit;
                end
            end
            StFlush: begin
                // Counter freezes while memory stalls the pipe.
                if (!mem_busy) begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = StRun;
                    end
                end
            end
            StWait: begin
                if (mem_busy) begin
                    if (branch_taken) begin
                        pend_d = 1'b1;
                    end
                end else begin
                    pend_d = 1'b0;
                    if (pend_q && HasFlush) begin
                        state_d = StFlush;
                        cnt_d   = FlushInit;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        hold       = 1'b0;
        lu_stall   = 1'b0;
        jump_reset = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_busy) begin
                    hold = 1'b1;
                end else if (branch_taken) begin
                    jump_reset = 1'b1;
                    accept     = 1'b1;
                end else begin
                    lu_stall = load_use;
                end
            end
            StFlush: begin
                jump_reset = 1'b1;
                hold       = mem_busy;
            end
            StWait: begin
                if (mem_busy) begin
                    hold = 1'b1;
                end else if (pend_q) begin
                    jump_reset = 1'b1;
                    accept     = 1'b1;
                end else begin
                    lu_stall = load_use;
                end
            end
            default: ;
        endcase
    end

    assign pc_stall = hold | lu_stall;
    assign D_stall  = hold | lu_stall;
    assign E_stop   = lu_stall;
    assign E_hold   = hold;
    assign M_stall  = hold;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (accept && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign stall_cnt     = '0;
    assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed vector table, corner sequences, random run.
module tb_hazard_stall_ctrl;

    localparam int unsigned FlushCycles = 1;
    localparam int unsigned CntW        = 32;

    // Sample instructions
    localparam logic [31:0] LwX5     = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] LwX0     = 32'h0000A003;  // lw   x0,0(x1)
    localparam logic [31:0] AddRs1X5 = 32'h00228333;  // add  x6,x5,x2
    localparam logic [31:0] AddRs1X0 = 32'h00200333;  // add  x6,x0,x2
    localparam logic [31:0] AddRs2X5 = 32'h00510333;  // add  x6,x2,x5
    localparam logic [31:0] LuiX5    = 32'h123452B7;  // lui  x5,0x12345
    localparam logic [31:0] SwX5     = 32'h00512023;  // sw   x5,0(x2)
    localparam logic [31:0] AddiX5   = 32'h00128393;  // addi x7,x5,1
    localparam logic [31:0] AddiImm5 = 32'h00508393;  // addi x7,x1,5
    localparam logic [31:0] JalF5    = 32'h000280EF;  // jal  with bits[19:15]=5
    localparam logic [31:0] AuipcF5  = 32'h00028297;  // auipc with bits[19:15]=5
    localparam logic [31:0] AddX5    = 32'h002082B3;  // add  x5,x1,x2

    localparam logic [5:0] OZero = 6'b000000;
    localparam logic [5:0] OLu   = 6'b111000;
    localparam logic [5:0] OHold = 6'b110110;
    localparam logic [5:0] OJmp  = 6'b000001;
    localparam logic [5:0] OHJmp = 6'b110111;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [31:0]     inst_D = '0, inst_E = '0;
    logic            branch_taken = 1'b0, mem_busy = 1'b0;
    logic            pc_stall, D_stall, E_stop, E_hold, M_stall, jump_reset;
    logic [CntW-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: remaining flush cycles, waiting flag, pending redirect, event tallies
    int     m_flush_left;
    bit     m_wait, m_pend, m_accept;
    longint m_stall, m_flush;
    logic [5:0] m_out;

    hazard_stall_ctrl #(
        .FLUSH_CYCLES (FlushCycles),
        .CNT_W        (CntW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_D       (inst_D),
        .inst_E       (inst_E),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_stall     (pc_stall),
        .D_stall      (D_stall),
        .E_stop       (E_stop),
        .E_hold       (E_hold),
        .M_stall      (M_stall),
        .jump_reset   (jump_reset),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [31:0] e;
        bit          bt;
        bit          mb;
        logic [5:0]  exp;
    } vec_t;

    function automatic bit model_load_use(input logic [31:0] d, input logic [31:0] e);
        logic [6:0] opd = d[6:0];
        logic [4:0] rd = e[11:7];
        bit r1, r2;
        if (e[6:0] != 7'h03 || rd == 5'd0) return 1'b0;
        r1 = (d != 32'd0) && !(opd inside {7'h37, 7'h17, 7'h6F});
        r2 = opd inside {7'h63, 7'h23, 7'h33};
        return (r1 && d[19:15] == rd) || (r2 && d[24:20] == rd);
    endfunction

    function automatic logic [5:0] got_out();
        return {pc_stall, D_stall, E_stop, E_hold, M_stall, jump_reset};
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_wait = 0;
        m_pend = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_eval();
        bit hold, lu, jr;
        hold = 0; lu = 0; jr = 0; m_accept = 0;
        if (m_flush_left > 0) begin
            jr = 1;
            hold = mem_busy;
        end else if (mem_busy) begin
            hold = 1;
        end else if (m_wait ? m_pend : branch_taken) begin
            jr = 1;
            m_accept = 1;
        end else begin
            lu = model_load_use(inst_D, inst_E);
        end
        m_out = {hold | lu, hold | lu, lu, hold, hold, jr};
    endtask

    task automatic model_step();
        if (m_out[5] && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (m_accept && m_flush < 64'hFFFF_FFFF) m_flush++;
        if (m_flush_left > 0) begin
            if (!mem_busy) m_flush_left--;
        end else if (m_wait) begin
            if (mem_busy) begin
                m_pend = m_pend | branch_taken;
            end else begin
                m_wait = 0;
                if (m_pend) m_flush_left = FlushCycles;
                m_pend = 0;
            end
        end else if (mem_busy) begin
            m_wait = 1;
            m_pend = branch_taken;
        end else if (branch_taken) begin
            m_flush_left = FlushCycles;
        end
    endtask

    task automatic cmp6(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs {pc,D,Estop,Ehold,M,jr} got %b want %b", name, got, exp);
        end
    endtask

    task automatic cmp_cnt(input string name);
        logic [CntW-1:0] es, ef;
`ifdef HAZARD_PERF_CNT_EN
        es = CntW'(m_stall);
        ef = CntW'(m_flush);
`else
        es = '0;
        ef = '0;
`endif
        n_cmp++;
        if (stall_cnt !== es || flush_cnt !== ef) begin
            n_fail++;
            $display("FAIL %s counters: stall %0d flush %0d want %0d %0d",
                     name, stall_cnt, flush_cnt, es, ef);
        end
    endtask

    task automatic cycle(input string name, input logic [31:0] d, input logic [31:0] e,
                         input bit bt, input bit mb, input bit has_exp, input logic [5:0] exp);
        @(negedge clk);
        inst_D = d;
        inst_E = e;
        branch_taken = bt;
        mem_busy = mb;
        #1;
        model_eval();
        cmp6({name, "/model"}, got_out(), m_out);
        if (has_exp) cmp6({name, "/table"}, got_out(), exp);
        cmp_cnt(name);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle("idle", '0, '0, 0, 0, 1'b0, OZero);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        inst_D = '0;
        inst_E = '0;
        branch_taken = 0;
        mem_busy = 0;
        rst = 1'b0;
        #1;
        model_reset();
        cmp6({name, "/in_reset"}, got_out(), OZero);
        cmp_cnt({name, "/in_reset"});
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vecs[$];
    logic [31:0] pool[12];

    initial begin
        model_reset();
        vecs.push_back('{"lu_rs1",     AddRs1X5, LwX5,  0, 0, OLu});
        vecs.push_back('{"lw_x0",      AddRs1X0, LwX0,  0, 0, OZero});
        vecs.push_back('{"lui_no_rs",  LuiX5,    LwX5,  0, 0, OZero});
        vecs.push_back('{"lu_rs2",     AddRs2X5, LwX5,  0, 0, OLu});
        vecs.push_back('{"lu_store",   SwX5,     LwX5,  0, 0, OLu});
        vecs.push_back('{"lu_itype",   AddiX5,   LwX5,  0, 0, OLu});
        vecs.push_back('{"imm_not_rs2", AddiImm5, LwX5, 0, 0, OZero});
        vecs.push_back('{"jal_no_rs",  JalF5,    LwX5,  0, 0, OZero});
        vecs.push_back('{"auipc_no_rs", AuipcF5, LwX5,  0, 0, OZero});
        vecs.push_back('{"e_not_load", AddRs1X5, AddX5, 0, 0, OZero});
        vecs.push_back('{"lu_and_br",  AddRs1X5, LwX5,  1, 0, OJmp});
        vecs.push_back('{"lu_and_busy", AddRs1X5, LwX5, 0, 1, OHold});
        vecs.push_back('{"busy_and_br", '0,      '0,    1, 1, OHold});

        // Reset state
        #1;
        cmp6("reset_outputs", got_out(), OZero);
        cmp_cnt("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].name, vecs[i].d, vecs[i].e, vecs[i].bt, vecs[i].mb, 1'b1, vecs[i].exp);
            idle(3);
        end

        // Branch redirect: second branch inside the flush window is wrong-path
        cycle("br_accept", '0, '0, 1, 0, 1'b1, OJmp);
        cycle("br_flush_ignore", '0, '0, 1, 0, 1'b1, OJmp);
        cycle("br_done", '0, '0, 0, 0, 1'b1, OZero);

        // Memory wait with a branch arriving mid-wait, then load-use held off by the redirect
        cycle("wait_c1", AddRs1X5, LwX5, 0, 1, 1'b1, OHold);
        cycle("wait_c2_br", AddRs1X5, LwX5, 1, 1, 1'b1, OHold);
        cycle("wait_c3", AddRs1X5, LwX5, 0, 1, 1'b1, OHold);
        cycle("wait_release", AddRs1X5, LwX5, 0, 0, 1'b1, OJmp);
        cycle("wait_flush", AddRs1X5, LwX5, 0, 0, 1'b1, OJmp);
        cycle("wait_then_lu", AddRs1X5, LwX5, 0, 0, 1'b1, OLu);
        idle(2);

        // Memory stall during flush freezes the flush window
        cycle("fb_branch", '0, '0, 1, 0, 1'b1, OJmp);
        cycle("fb_busy", '0, '0, 0, 1, 1'b1, OHJmp);
        cycle("fb_resume", '0, '0, 0, 0, 1'b1, OJmp);
        cycle("fb_done", '0, '0, 0, 0, 1'b1, OZero);

        // Release without pending redirect evaluates load-use
        cycle("rl_busy", AddRs2X5, LwX5, 0, 1, 1'b1, OHold);
        cycle("rl_lu", AddRs2X5, LwX5, 0, 0, 1'b1, OLu);
        idle(2);

        // Reset in WAIT with a redirect pending drops it
        cycle("rw_busy_br", '0, '0, 1, 1, 1'b1, OHold);
        cycle("rw_busy", '0, '0, 0, 1, 1'b1, OHold);
        do_reset("rw");
        cycle("rw_after", '0, '0, 0, 0, 1'b1, OZero);
        cycle("rw_after2", '0, '0, 0, 0, 1'b1, OZero);

        // Randomized run against the model
        pool = '{LwX5, LwX0, AddRs1X5, AddRs1X0, AddRs2X5, LuiX5, SwX5, AddiX5,
                 AddiImm5, JalF5, AuipcF5, AddX5};
        for (int i = 0; i < 800; i++) begin
            logic [31:0] d, e;
            d = pool[$urandom_range(0, 11)];
            e = ($urandom_range(0, 1) == 0) ? LwX5 : pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
            cycle("rand", d, e, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                  1'b0, OZero);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
